// File: rtl/biquad8_output_monitor_if.sv
// Tap-side bundle for the biquad8 output monitor: chain output beat, enable,
// read strobe and the latched window results with their flags.
// master = the block feeding samples / reading results, slave = the monitor.
interface biquad8_output_monitor_if #(
  parameter int NBITS    = 16,
  parameter int NSAMP    = 8,
  parameter int CNT_BITS = 24
);
  logic                   en_i;
  logic [NBITS*NSAMP-1:0] dat_i;
  logic                   results_read_i;
  logic [NBITS-1:0]       peak_o;
  logic [CNT_BITS-1:0]    clip_count_o;
  logic [NBITS-1:0]       max_o;
  logic [NBITS-1:0]       min_o;
  logic                   results_valid_o;
  logic                   overrun_o;

  modport master (
    output en_i, dat_i, results_read_i,
    input  peak_o, clip_count_o, max_o, min_o, results_valid_o, overrun_o
  );

  modport slave (
    input  en_i, dat_i, results_read_i,
    output peak_o, clip_count_o, max_o, min_o, results_valid_o, overrun_o
  );
endinterface

// File: rtl/biquad8_output_monitor.sv
// Windowed peak-|x| / clip-count monitor on the 8-sample/clk biquad chain output.
// Latency: results latched on the edge 3 clks after the window's last beat is sampled.
// Backpressure: none; passive tap, an unread result is kept and overrun flagged.
// Optional signed max/min tracking: define BIQUAD8_MON_MINMAX_EN (else max_o/min_o = 0).
module biquad8_output_monitor #(
  parameter int NBITS       = 16,
  parameter int NSAMP       = 8,
  parameter int WINDOW_LOG2 = 16,
  parameter int CNT_BITS    = 24
) (
  input logic                     clk_i,
  input logic                     rst_i,
  biquad8_output_monitor_if.slave mon
);

  localparam int PCW = $clog2(NSAMP + 1);
  localparam int SW  = CNT_BITS + 1;
  localparam logic [NBITS-1:0] POS_FS = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic [NBITS-1:0] NEG_FS = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [NBITS-1:0] ONE    = {{(NBITS-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  logic en;
  logic rd;
  assign en = mon.en_i;
  assign rd = mon.results_read_i;

  // ---------------------------------------------------------------- control
  state_t                 state;
  logic [WINDOW_LOG2-1:0] beat_cnt;
  logic [NBITS*NSAMP-1:0] tap_dat;
  logic                   tap_vld;
  logic                   tap_first;
  logic                   tap_last;

  // Run/idle FSM, beat position in window, and capture of the tapped beat.
  // Dropping en clears the beat position so the next enabled beat is beat 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      tap_dat   <= '0;
      tap_vld   <= 1'b0;
      tap_first <= 1'b0;
      tap_last  <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (en)  state <= RUN;
        RUN:     if (!en) state <= IDLE;
        default: state <= IDLE;
      endcase
      tap_dat   <= mon.dat_i;
      tap_vld   <= en;
      tap_first <= en && ((state == IDLE) || (beat_cnt == '0));
      tap_last  <= en && (beat_cnt == '1);
      beat_cnt  <= en ? beat_cnt + 1'b1 : '0;
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic [NBITS-1:0] abs_c [NSAMP];
  logic [NSAMP-1:0] clip_c;

  // Per-sample magnitude and full-scale detect. The negation of -FS lands on
  // 2**(NBITS-1), which is representable as NBITS unsigned, so nothing wraps.
  always_comb begin
    clip_c = '0;
    for (int k = 0; k < NSAMP; k++) begin
      abs_c[k]  = tap_dat[k*NBITS + NBITS - 1] ? ((~tap_dat[k*NBITS +: NBITS]) + ONE)
                                                : tap_dat[k*NBITS +: NBITS];
      clip_c[k] = (tap_dat[k*NBITS +: NBITS] == POS_FS) ||
                  (tap_dat[k*NBITS +: NBITS] == NEG_FS);
    end
  end

  logic [NBITS-1:0] s1_abs [NSAMP];
  logic [NSAMP-1:0] s1_clip;
  logic             s1_vld;
  logic             s1_first;
  logic             s1_last;

  // Stage 1 register; a low en flushes the beat in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NSAMP; k++) s1_abs[k] <= '0;
      s1_clip  <= '0;
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      for (int k = 0; k < NSAMP; k++) s1_abs[k] <= abs_c[k];
      s1_clip  <= clip_c;
      s1_vld   <= en && tap_vld;
      s1_first <= tap_first;
      s1_last  <= tap_last;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [NBITS-1:0] red_peak;
  logic [PCW-1:0]   red_pop;

  // Reduce one beat: largest magnitude and number of clipped samples.
  always_comb begin
    red_peak = '0;
    red_pop  = '0;
    for (int k = 0; k < NSAMP; k++) begin
      if (s1_abs[k] > red_peak) red_peak = s1_abs[k];
      red_pop = red_pop + PCW'(s1_clip[k]);
    end
  end

  logic [NBITS-1:0] s2_peak;
  logic [PCW-1:0]   s2_pop;
  logic             s2_vld;
  logic             s2_first;
  logic             s2_last;

  // Stage 2 register; same flush rule as stage 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_peak  <= '0;
      s2_pop   <= '0;
      s2_vld   <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      s2_peak  <= red_peak;
      s2_pop   <= red_pop;
      s2_vld   <= en && s1_vld;
      s2_first <= s1_first;
      s2_last  <= s1_last;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [NBITS-1:0]    acc_peak;
  logic [CNT_BITS-1:0] acc_cnt;
  logic [NBITS-1:0]    nxt_peak;
  logic [CNT_BITS-1:0] nxt_cnt;
  logic [SW-1:0]       cnt_sum;

  // Next accumulator value: the first beat of a window loads, later beats
  // combine. The clip count sticks at all-ones once it overflows.
  always_comb begin
    cnt_sum = {1'b0, acc_cnt} + SW'(s2_pop);
    if (s2_first) begin
      nxt_peak = s2_peak;
      nxt_cnt  = CNT_BITS'(s2_pop);
    end else begin
      nxt_peak = (s2_peak > acc_peak) ? s2_peak : acc_peak;
      nxt_cnt  = cnt_sum[CNT_BITS] ? '1 : cnt_sum[CNT_BITS-1:0];
    end
  end

  // Window completes when stage 3 absorbs a last beat while still enabled.
  logic done;
  logic latch_en;
  assign done     = en && s2_vld && s2_last;
  assign latch_en = done && (!mon.results_valid_o || rd);

  // Accumulators; cleared whenever the monitor is disabled.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en) begin
      acc_peak <= '0;
      acc_cnt  <= '0;
    end else if (s2_vld) begin
      acc_peak <= nxt_peak;
      acc_cnt  <= nxt_cnt;
    end
  end

  // ---------------------------------------------------------------- results
  logic [NBITS-1:0]    res_peak;
  logic [CNT_BITS-1:0] res_cnt;
  logic                res_vld;
  logic                res_ovr;

  // Result registers and flags. An unread result is never overwritten; a read
  // coinciding with a completion frees the slot in the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_peak <= '0;
      res_cnt  <= '0;
      res_vld  <= 1'b0;
      res_ovr  <= 1'b0;
    end else if (done) begin
      if (latch_en) begin
        res_peak <= nxt_peak;
        res_cnt  <= nxt_cnt;
        res_vld  <= 1'b1;
        if (rd) res_ovr <= 1'b0;
      end else begin
        res_ovr <= 1'b1;
      end
    end else if (rd && res_vld) begin
      res_vld <= 1'b0;
      res_ovr <= 1'b0;
    end
  end

  assign mon.peak_o          = res_peak;
  assign mon.clip_count_o    = res_cnt;
  assign mon.results_valid_o = res_vld;
  assign mon.overrun_o       = res_ovr;

`ifdef BIQUAD8_MON_MINMAX_EN
  // ------------------------------------------------------ signed max / min
  logic [NBITS*NSAMP-1:0] s1_dat;
  logic [NBITS-1:0]       red_max;
  logic [NBITS-1:0]       red_min;
  logic [NBITS-1:0]       s2_max;
  logic [NBITS-1:0]       s2_min;
  logic [NBITS-1:0]       acc_max;
  logic [NBITS-1:0]       acc_min;
  logic [NBITS-1:0]       nxt_max;
  logic [NBITS-1:0]       nxt_min;
  logic [NBITS-1:0]       res_max;
  logic [NBITS-1:0]       res_min;

  // Raw samples travel alongside stage 1 for the signed extremes.
  always_ff @(posedge clk_i) begin
    if (rst_i) s1_dat <= '0;
    else       s1_dat <= tap_dat;
  end

  // Signed extremes of one beat.
  always_comb begin
    red_max = s1_dat[NBITS-1:0];
    red_min = s1_dat[NBITS-1:0];
    for (int k = 1; k < NSAMP; k++) begin
      if ($signed(s1_dat[k*NBITS +: NBITS]) > $signed(red_max)) red_max = s1_dat[k*NBITS +: NBITS];
      if ($signed(s1_dat[k*NBITS +: NBITS]) < $signed(red_min)) red_min = s1_dat[k*NBITS +: NBITS];
    end
  end

  // Stage 2 register for the extremes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_max <= '0;
      s2_min <= '0;
    end else begin
      s2_max <= red_max;
      s2_min <= red_min;
    end
  end

  // Running extremes; first beat of a window loads.
  always_comb begin
    if (s2_first) begin
      nxt_max = s2_max;
      nxt_min = s2_min;
    end else begin
      nxt_max = ($signed(s2_max) > $signed(acc_max)) ? s2_max : acc_max;
      nxt_min = ($signed(s2_min) < $signed(acc_min)) ? s2_min : acc_min;
    end
  end

  // Extreme accumulators, cleared with the others.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en) begin
      acc_max <= '0;
      acc_min <= '0;
    end else if (s2_vld) begin
      acc_max <= nxt_max;
      acc_min <= nxt_min;
    end
  end

  // Extreme results latched together with peak and clip count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_max <= '0;
      res_min <= '0;
    end else if (latch_en) begin
      res_max <= nxt_max;
      res_min <= nxt_min;
    end
  end

  assign mon.max_o = res_max;
  assign mon.min_o = res_min;
`else
  assign mon.max_o = '0;
  assign mon.min_o = '0;
`endif

endmodule

// File: tb/tb_biquad8_output_monitor.sv
// Bench for biquad8_output_monitor: two instances (16- and 64-beat windows)
// share one stimulus stream; a window-level reference model predicts outputs
// after every clock edge.
module tb_biquad8_output_monitor;
  localparam int NB = 16;
  localparam int NS = 8;
  localparam int CB = 8;
  localparam int DW = NB * NS;
  localparam int CNT_MAX = (1 << CB) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  biquad8_output_monitor_if #(.NBITS(NB), .NSAMP(NS), .CNT_BITS(CB)) bus4 ();
  biquad8_output_monitor_if #(.NBITS(NB), .NSAMP(NS), .CNT_BITS(CB)) bus6 ();

  biquad8_output_monitor #(.NBITS(NB), .NSAMP(NS), .WINDOW_LOG2(4), .CNT_BITS(CB)) dut4 (
    .clk_i(clk), .rst_i(rst), .mon(bus4));
  biquad8_output_monitor #(.NBITS(NB), .NSAMP(NS), .WINDOW_LOG2(6), .CNT_BITS(CB)) dut6 (
    .clk_i(clk), .rst_i(rst), .mon(bus6));

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: beats of the current enabled run, and expected outputs.
  logic [DW-1:0] q[$];
  int            run_pos = -1;
  int            win_len [2] = '{16, 64};
  logic [15:0]   e_peak  [2];
  int            e_clip  [2];
  shortint       e_max   [2];
  shortint       e_min   [2];
  bit            e_vld   [2];
  bit            e_ovr   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      e_peak[i] = '0; e_clip[i] = 0; e_max[i] = 0; e_min[i] = 0;
      e_vld[i] = 1'b0; e_ovr[i] = 1'b0;
    end
    q.delete();
    run_pos = -1;
  endtask

  // Statistics over the n beats ending 3 beats before the newest one.
  task automatic win_stats(input int n, output logic [15:0] pk, output int cl,
                           output shortint mx, output shortint mn);
    int base;
    int a;
    shortint s;
    logic [DW-1:0] b;
    pk = '0; cl = 0; mx = -32768; mn = 32767;
    base = q.size() - 3 - n;
    for (int j = 0; j < n; j++) begin
      b = q[base + j];
      for (int k = 0; k < NS; k++) begin
        s = shortint'(b[k*NB +: NB]);
        a = (s < 0) ? -int'(s) : int'(s);
        if (a > int'(pk)) pk = 16'(a);
        if (s == 32767 || s == -32768) cl++;
        if (s > mx) mx = s;
        if (s < mn) mn = s;
      end
    end
    if (cl > CNT_MAX) cl = CNT_MAX;
  endtask

  task automatic model_edge(input bit r, input bit e, input logic [DW-1:0] d, input bit rd);
    bit          done;
    logic [15:0] pk;
    int          cl;
    shortint     mx, mn;
    if (r) begin
      model_reset();
      return;
    end
    if (e) begin
      q.push_back(d);
      if (q.size() > 80) void'(q.pop_front());
      run_pos++;
    end else begin
      q.delete();
      run_pos = -1;
    end
    for (int i = 0; i < 2; i++) begin
      done = e && (run_pos >= 3) && (((run_pos - 2) % win_len[i]) == 0);
      if (done) begin
        win_stats(win_len[i], pk, cl, mx, mn);
        if (e_vld[i] && !rd) begin
          e_ovr[i] = 1'b1;
        end else begin
          e_peak[i] = pk; e_clip[i] = cl; e_max[i] = mx; e_min[i] = mn;
          e_vld[i] = 1'b1;
          if (rd) e_ovr[i] = 1'b0;
        end
      end else if (rd && e_vld[i]) begin
        e_vld[i] = 1'b0;
        e_ovr[i] = 1'b0;
      end
    end
  endtask

  task automatic cmp_inst(input string nm, input int i, input logic [15:0] pk,
                          input logic [CB-1:0] cl, input logic [15:0] mx, input logic [15:0] mn,
                          input logic v, input logic o);
    logic [15:0] xmax, xmin;
`ifdef BIQUAD8_MON_MINMAX_EN
    xmax = 16'(e_max[i]);
    xmin = 16'(e_min[i]);
`else
    xmax = '0;
    xmin = '0;
`endif
    chk({nm, "_peak"},  {16'b0, pk},      {16'b0, e_peak[i]});
    chk({nm, "_clip"},  32'(cl),          32'(e_clip[i]));
    chk({nm, "_max"},   {16'b0, mx},      {16'b0, xmax});
    chk({nm, "_min"},   {16'b0, mn},      {16'b0, xmin});
    chk({nm, "_valid"}, {31'b0, v},       {31'b0, e_vld[i]});
    chk({nm, "_ovr"},   {31'b0, o},       {31'b0, e_ovr[i]});
  endtask

  task automatic step(input bit r, input bit e, input logic [DW-1:0] d, input bit rd);
    rst = r;
    bus4.en_i = e; bus4.dat_i = d; bus4.results_read_i = rd;
    bus6.en_i = e; bus6.dat_i = d; bus6.results_read_i = rd;
    @(posedge clk);
    model_edge(r, e, d, rd);
    #1;
    cmp_inst("w16", 0, bus4.peak_o, bus4.clip_count_o, bus4.max_o, bus4.min_o,
             bus4.results_valid_o, bus4.overrun_o);
    cmp_inst("w64", 1, bus6.peak_o, bus6.clip_count_o, bus6.max_o, bus6.min_o,
             bus6.results_valid_o, bus6.overrun_o);
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] b;
    for (int k = 0; k < NS; k++) begin
      case ($urandom_range(0, 7))
        0:       b[k*NB +: NB] = 16'h7fff;
        1:       b[k*NB +: NB] = 16'h8000;
        2:       b[k*NB +: NB] = 16'($urandom_range(0, 15)) - 16'd8;
        default: b[k*NB +: NB] = 16'($urandom);
      endcase
    end
    return b;
  endfunction

  logic [DW-1:0] d100, dclip, dneg, dz;
  bit            rdp;

  initial begin
    d100  = {NS{16'd100}};
    dclip = {NS{16'h7fff}};
    dz    = '0;
    dneg  = '0;
    dneg[3*NB +: NB] = 16'h8000;
    bus4.en_i = 1'b0; bus4.dat_i = '0; bus4.results_read_i = 1'b0;
    bus6.en_i = 1'b0; bus6.dat_i = '0; bus6.results_read_i = 1'b0;
    model_reset();

    // Reset, then one window of constant 100.
    repeat (3) step(1'b1, 1'b0, dz, 1'b0);
    for (int j = 0; j < 16; j++) step(1'b0, 1'b1, d100, 1'b0);
    for (int j = 0; j < 3; j++)  step(1'b0, 1'b1, dz, 1'b0);
    step(1'b0, 1'b0, dz, 1'b0);
    step(1'b0, 1'b0, dz, 1'b1);

    // One -FS sample, one all +FS beat, rest zero.
    step(1'b0, 1'b1, dneg, 1'b0);
    step(1'b0, 1'b1, dclip, 1'b0);
    for (int j = 0; j < 17; j++) step(1'b0, 1'b1, dz, 1'b0);
    step(1'b0, 1'b0, dz, 1'b1);

    // Three windows unread -> first kept, overrun; then read clears both.
    for (int j = 0; j < 51; j++) step(1'b0, 1'b1, rand_beat(), 1'b0);
    step(1'b0, 1'b0, dz, 1'b1);
    step(1'b0, 1'b0, dz, 1'b0);

    // All-clip run with reads after each result: 128 per short window, 255 saturated long.
    for (int j = 0; j < 70; j++) step(1'b0, 1'b1, dclip, e_vld[0] && !e_vld[1]);
    step(1'b0, 1'b0, dz, 1'b1);

    // en low for one clk at beat 7, then a fresh window; then rst at beat 10.
    for (int j = 0; j < 7; j++)  step(1'b0, 1'b1, rand_beat(), 1'b0);
    step(1'b0, 1'b0, rand_beat(), 1'b0);
    for (int j = 0; j < 19; j++) step(1'b0, 1'b1, rand_beat(), 1'b0);
    for (int j = 0; j < 10; j++) step(1'b0, 1'b1, rand_beat(), 1'b0);
    step(1'b1, 1'b1, rand_beat(), 1'b0);

    // Reads coincident with window completion while a result is pending.
    for (int j = 0; j < 67; j++) begin
      rdp = e_vld[0] && (run_pos + 1 >= 3) && (((run_pos - 1) % 16) == 0);
      step(1'b0, 1'b1, rand_beat(), rdp);
    end
    step(1'b0, 1'b0, dz, 1'b1);

    // Randomized traffic.
    for (int j = 0; j < 2500; j++)
      step($urandom_range(0, 999) == 0, $urandom_range(0, 99) != 0, rand_beat(),
           $urandom_range(0, 9) == 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
